rc4_decrypt_fsm: RTL and testbench

RC4 decryption stage (FSM3) that runs after memory initialization and key shuffle have filled the S memory. On `start` it requests the S-memory port from the memory handler. It then runs the RC4 PRGA over `MSG_LEN` bytes: it reads and swaps S, reads each encrypted byte from the message ROM, and writes the plaintext to the decrypted RAM. It aborts early on a non-printable plaintext byte so a key-search controller can move on to the next key.

---
 rtl/rc4_decrypt_fsm.sv | 177 +++++++++++++++++
 tb/tb_rc4_decrypt_fsm.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_decrypt_fsm.sv
// rc4_decrypt_fsm
//   RC4 PRGA decryption stage. Once S has been initialised and key-shuffled,
//   a `start` makes this block request the S-memory port, then for each of
//   MSG_LEN bytes it reads/swaps S, fetches the keystream byte, XORs it with
//   the encrypted ROM byte and writes the plaintext to the decrypted RAM.
//   A plaintext byte outside {0x20, 0x61..0x7A} aborts the run early and
//   raises `char_invalid` so a key-search controller can try the next key.
//
// Ports
//   clk, reset_n         clock, asynchronous active-low reset
//   start                level request, sampled only in IDLE
//   busy                 high in every state except IDLE
//   finish               one-cycle pulse in DONE
//   char_invalid         sticky abort flag, cleared when a start is accepted
//   mem_req / mem_gnt    S-memory ownership handshake with the memory handler
//   s_address/s_data/s_wren/s_q   S memory port (1-cycle read latency)
//   rom_address/rom_q    encrypted-message ROM (address is the byte index k)
//   d_address/d_data/d_wren       decrypted-message RAM write port
module rc4_decrypt_fsm #(
   parameter int MSG_LEN = 32,
   localparam int AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          start,
   output logic          busy,
   output logic          finish,
   output logic          char_invalid,
   output logic          mem_req,
   input  logic          mem_gnt,
   output logic [7:0]    s_address,
   output logic [7:0]    s_data,
   output logic          s_wren,
   input  logic [7:0]    s_q,
   output logic [AW-1:0] rom_address,
   input  logic [7:0]    rom_q,
   output logic [AW-1:0] d_address,
   output logic [7:0]    d_data,
   output logic          d_wren
);

   localparam logic [AW-1:0] K_LAST = AW'(MSG_LEN - 1);

   typedef enum logic [3:0] {
      IDLE,
      REQ,
      RD_SI,
      WAIT_SI,
      RD_SJ,
      WAIT_SJ,
      WR_SI,
      WR_SJ,
      RD_F,
      WAIT_F,
      WR_D,
      DONE
   } state_t;

   state_t state, nxt;

   logic [7:0]    i, j, si, sj, f;
   logic [AW-1:0] k;
   logic [7:0]    pt;
   logic          pt_ok;

   // rom_q has been stable for several cycles by the time WR_D is reached,
   // so the plaintext can be formed combinationally from the captured f.
   assign pt    = f ^ rom_q;
   assign pt_ok = ((pt >= 8'h61) && (pt <= 8'h7A)) || (pt == 8'h20);

   assign rom_address = k;

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= nxt;
   end

   // ----------------------------------------------------------- next state
   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:    if (start)   nxt = REQ;
         REQ:     if (mem_gnt) nxt = RD_SI;
         RD_SI:   nxt = WAIT_SI;
         WAIT_SI: nxt = RD_SJ;
         RD_SJ:   nxt = WAIT_SJ;
         WAIT_SJ: nxt = WR_SI;
         WR_SI:   nxt = WR_SJ;
         WR_SJ:   nxt = RD_F;
         RD_F:    nxt = WAIT_F;
         WAIT_F:  nxt = WR_D;
         WR_D:    nxt = (!pt_ok || (k == K_LAST)) ? DONE : RD_SI;
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // -------------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         i            <= '0;
         j            <= '0;
         k            <= '0;
         si           <= '0;
         sj           <= '0;
         f            <= '0;
         char_invalid <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  i            <= '0;
                  j            <= '0;
                  k            <= '0;
                  si           <= '0;
                  sj           <= '0;
                  f            <= '0;
                  char_invalid <= 1'b0;
               end
            end
            RD_SI:   i <= i + 8'd1;
            // j uses the freshly read S[i] directly; si is only a copy for
            // the later swap and the f-address sum.
            WAIT_SI: begin
               si <= s_q;
               j  <= j + s_q;
            end
            WAIT_SJ: sj <= s_q;
            WAIT_F:  f  <= s_q;
            WR_D: begin
               if (!pt_ok)           char_invalid <= 1'b1;
               else if (k != K_LAST) k <= k + AW'(1);
            end
            default: ;
         endcase
      end
   end

   // --------------------------------------------------------------- outputs
   // i == j needs no special case: WR_SJ lands on the same word after WR_SI
   // and leaves S[i] = si, which is exactly what a swap with itself means.
   always_comb begin
      busy      = (state != IDLE);
      finish    = (state == DONE);
      mem_req   = (state != IDLE) && (state != DONE);
      s_address = '0;
      s_data    = '0;
      s_wren    = 1'b0;
      d_address = '0;
      d_data    = '0;
      d_wren    = 1'b0;
      unique case (state)
         RD_SI: s_address = i + 8'd1;
         RD_SJ: s_address = j;
         WR_SI: begin
            s_address = i;
            s_data    = sj;
            s_wren    = 1'b1;
         end
         WR_SJ: begin
            s_address = j;
            s_data    = si;
            s_wren    = 1'b1;
         end
         RD_F:  s_address = si + sj;
         WR_D: begin
            // the offending byte of an abort is still written
            d_address = k;
            d_data    = pt;
            d_wren    = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_rc4_decrypt_fsm.sv
// Bench for rc4_decrypt_fsm: S-memory and ROM models, an RC4 reference that
// expands each job into its per-cycle expected outputs, and one compare
// process that checks the DUT against that trace every cycle of a run.
module tb_rc4_decrypt_fsm;

   localparam int L  = 4;
   localparam int AW = 2;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic          mem_gnt = 1'b1;
   logic          busy, finish, char_invalid, mem_req, s_wren, d_wren;
   logic [7:0]    s_address, s_data, s_q, rom_q, d_data;
   logic [AW-1:0] rom_address, d_address;

   rc4_decrypt_fsm #(.MSG_LEN(L)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .busy(busy),
      .finish(finish), .char_invalid(char_invalid), .mem_req(mem_req),
      .mem_gnt(mem_gnt), .s_address(s_address), .s_data(s_data),
      .s_wren(s_wren), .s_q(s_q), .rom_address(rom_address), .rom_q(rom_q),
      .d_address(d_address), .d_data(d_data), .d_wren(d_wren)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // memories around the DUT
   logic [7:0] smem   [256];
   logic [7:0] ld_img [256];
   logic       ld = 1'b0;
   logic [7:0] rom    [L];

   always @(posedge clk) begin
      if (ld) begin
         for (int a = 0; a < 256; a++) smem[a] <= ld_img[a];
      end else if (s_wren) begin
         smem[s_address] <= s_data;
      end
      s_q <= smem[s_address];
   end

   always @(posedge clk) rom_q <= rom[rom_address];

   // reference model state
   typedef struct {
      logic busy, fin, inv, req, swe, sachk, dwe;
      logic [7:0] sa, sd, dd;
      logic [AW-1:0] ra;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] ms [256];
   logic [7:0] ks [L];
   logic [7:0] pd [L];
   int         last_k;
   int         checks = 0, errors = 0;
   int         e0 = 0, fin_cnt = 0, fin_cyc = 0;
   bit         chk_on = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
      checks++;
      if (act !== ex) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, ex, cyc - e0);
      end
   endtask

   function automatic bit printable(input logic [7:0] p);
      return ((p >= 8'h61) && (p <= 8'h7A)) || (p == 8'h20);
   endfunction

   function automatic logic [7:0] pick_valid();
      int r;
      r = $urandom_range(0, 26);
      return (r == 26) ? 8'h20 : 8'(8'h61 + r);
   endfunction

   function automatic void push(input int b, fn, iv, rq, we, sc, dw, sa, sd, dd, kk);
      exp_t e;
      e.busy = 1'(b);  e.fin = 1'(fn); e.inv = 1'(iv); e.req = 1'(rq);
      e.swe = 1'(we);  e.sachk = 1'(sc); e.dwe = 1'(dw);
      e.sa = 8'(sa);   e.sd = 8'(sd); e.dd = 8'(dd); e.ra = AW'(kk);
      exp_q.push_back(e);
   endfunction

   // RC4 PRGA on the model S, emitted as one expected entry per cycle.
   // rnd: choose each ROM byte so that the plaintext is mostly printable.
   function automatic void build_job(input int gdly, input bit rnd);
      logic [7:0] i, j, si, sj, t, f, p;
      bit bad;
      i = 0; j = 0; bad = 0; last_k = 0;
      for (int n = 0; n <= gdly; n++) push(1,0,0,1,0,1,0,0,0,0,0);
      for (int k = 0; k < L; k++) begin
         last_k = k;
         i = i + 8'd1;
         push(1,0,0,1,0,1,0,i,0,0,k);
         si = ms[i];
         j = j + si;
         push(1,0,0,1,0,0,0,0,0,0,k);
         push(1,0,0,1,0,1,0,j,0,0,k);
         sj = ms[j];
         push(1,0,0,1,0,0,0,0,0,0,k);
         push(1,0,0,1,1,1,0,i,sj,0,k);
         push(1,0,0,1,1,1,0,j,si,0,k);
         ms[i] = sj;
         ms[j] = si;
         t = si + sj;
         push(1,0,0,1,0,1,0,t,0,0,k);
         f = ms[t];
         push(1,0,0,1,0,0,0,0,0,0,k);
         if (rnd) rom[k] = ($urandom_range(0, 7) == 0) ? 8'($urandom) : (f ^ pick_valid());
         p = f ^ rom[k];
         ks[k] = f;
         pd[k] = p;
         push(1,0,0,1,0,0,1,0,0,p,k);
         if (!printable(p)) begin
            bad = 1;
            break;
         end
      end
      push(1,1,bad,0,0,0,0,0,0,0,last_k);
      push(0,0,bad,0,0,0,0,0,0,0,last_k);
   endfunction

   // compare process
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (chk_on && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("busy", 32'(busy), 32'(e.busy));
            chk("finish", 32'(finish), 32'(e.fin));
            chk("char_invalid", 32'(char_invalid), 32'(e.inv));
            chk("mem_req", 32'(mem_req), 32'(e.req));
            chk("s_wren", 32'(s_wren), 32'(e.swe));
            chk("d_wren", 32'(d_wren), 32'(e.dwe));
            chk("rom_address", 32'(rom_address), 32'(e.ra));
            if (e.sachk) chk("s_address", 32'(s_address), 32'(e.sa));
            if (e.swe)   chk("s_data", 32'(s_data), 32'(e.sd));
            if (e.dwe) begin
               chk("d_address", 32'(d_address), 32'(e.ra));
               chk("d_data", 32'(d_data), 32'(e.dd));
            end
            if (finish) begin
               fin_cnt++;
               fin_cyc = cyc - e0;
            end
         end
      end
   end

   task automatic set_identity();
      for (int a = 0; a < 256; a++) ld_img[a] = 8'(a);
   endtask

   task automatic load_img();
      for (int a = 0; a < 256; a++) ms[a] = ld_img[a];
      ld = 1'b1;
      @(posedge clk);
      #1 ld = 1'b0;
   endtask

   task automatic set_rom(input logic [31:0] w);
      for (int a = 0; a < L; a++) rom[a] = w[31-8*a -: 8];
   endtask

   // Drive start across edge 0; returns in cycle 1 (or after the grant).
   task automatic start_job(input int gdly, input bit hold);
      if (gdly > 0) mem_gnt = 1'b0;
      fin_cnt = 0;
      start = 1'b1;
      @(posedge clk);
      #1;
      e0 = cyc - 1;
      chk_on = 1'b1;
      if (!hold) start = 1'b0;
      if (gdly > 0) begin
         repeat (gdly) @(posedge clk);
         #1 mem_gnt = 1'b1;
      end
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("run_completes", 32'(exp_q.size()), 0);
      exp_q.delete();
      chk_on = 1'b0;
   endtask

   task automatic check_s();
      int bad;
      bad = 0;
      for (int a = 0; a < 256; a++) if (smem[a] !== ms[a]) bad++;
      chk("s_mem_final", 32'(bad), 0);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_finish"}, 32'(finish), 0);
      chk({tag, "_char_invalid"}, 32'(char_invalid), 0);
      chk({tag, "_mem_req"}, 32'(mem_req), 0);
      chk({tag, "_s_address"}, 32'(s_address), 0);
      chk({tag, "_s_data"}, 32'(s_data), 0);
      chk({tag, "_s_wren"}, 32'(s_wren), 0);
      chk({tag, "_rom_address"}, 32'(rom_address), 0);
      chk({tag, "_d_address"}, 32'(d_address), 0);
      chk({tag, "_d_data"}, 32'(d_data), 0);
      chk({tag, "_d_wren"}, 32'(d_wren), 0);
   endtask

   task automatic normal_run(input int gdly, input int fin_exp);
      set_identity();
      load_img();
      set_rom(32'h63676469);
      build_job(gdly, 0);
      start_job(gdly, 0);
      wait_idle(300);
      chk("normal_finish_cycle", 32'(fin_cyc), 32'(fin_exp));
      chk("normal_finish_pulses", 32'(fin_cnt), 1);
      chk("normal_char_invalid", 32'(char_invalid), 0);
      chk("normal_s2", 32'(smem[2]), 32'h03);
      chk("normal_s3", 32'(smem[3]), 32'h05);
      chk("normal_s4", 32'(smem[4]), 32'h09);
      chk("normal_s5", 32'(smem[5]), 32'h02);
      chk("normal_s9", 32'(smem[9]), 32'h04);
      check_s();
   endtask

   initial begin
      int gd, n;
      logic [7:0] tmp;
      int r;

      // reset state
      #2;
      check_all_zero("reset");
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;

      // normal 4-byte run; pin the model with the hand-computed keystream
      set_identity();
      for (int a = 0; a < 256; a++) ms[a] = ld_img[a];
      set_rom(32'h63676469);
      build_job(0, 0);
      exp_q.delete();
      chk("model_ks", {ks[0], ks[1], ks[2], ks[3]}, 32'h0205070D);
      chk("model_pt", {pd[0], pd[1], pd[2], pd[3]}, 32'h61626364);
      normal_run(0, 38);

      // early abort on byte 0
      set_identity();
      load_img();
      set_rom(32'h00000000);
      build_job(0, 0);
      chk("abort_model_pt0", 32'(pd[0]), 32'h02);
      start_job(0, 0);
      wait_idle(100);
      chk("abort_finish_cycle", 32'(fin_cyc), 11);
      chk("abort_char_invalid", 32'(char_invalid), 1);

      // wrap-around of j; also checks char_invalid clears on start
      set_identity();
      ld_img[1] = 8'hFF;
      ld_img[255] = 8'h01;
      load_img();
      set_rom(32'h20000000);
      build_job(0, 0);
      chk("wrap_model_ks0", 32'(ks[0]), 32'h00);
      chk("wrap_model_pt0", 32'(pd[0]), 32'h20);
      start_job(0, 0);
      chk("invalid_cleared_on_start", 32'(char_invalid), 0);
      wait_idle(100);
      check_s();

      // grant held off for 5 cycles
      normal_run(5, 43);

      // reset during WR_SJ of byte 1 (cycle 16)
      set_identity();
      load_img();
      set_rom(32'h63676469);
      build_job(0, 0);
      start_job(0, 0);
      repeat (15) @(posedge clk);
      #1;
      chk("pre_reset_s_wren", 32'(s_wren), 1);
      exp_q.delete();
      chk_on = 1'b0;
      reset_n = 1'b0;
      #1;
      check_all_zero("midreset");
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      normal_run(0, 38);

      // start pulses during byte 2 and during DONE are ignored
      set_identity();
      load_img();
      set_rom(32'h63676469);
      build_job(0, 0);
      start_job(0, 0);
      repeat (21) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      while (cyc - e0 < 38) begin
         @(posedge clk);
         #1;
      end
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_idle(100);
      chk("busy_start_no_restart", 32'(busy), 0);
      chk("busy_start_one_finish", 32'(fin_cnt), 1);
      check_s();

      // back-to-back runs with start held high
      set_identity();
      load_img();
      set_rom(32'h63676469);
      build_job(0, 0);
      build_job(0, 0);
      start_job(0, 1);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!finish && n < 100);
      chk("b2b_first_finish_seen", 32'(finish), 1);
      @(posedge clk);
      @(posedge clk);
      #1 start = 1'b0;
      wait_idle(200);
      chk("b2b_finish_pulses", 32'(fin_cnt), 2);
      check_s();

      // randomized S permutations, ROM contents and grant delays
      for (int it = 0; it < 12; it++) begin
         set_identity();
         for (int a = 255; a > 0; a--) begin
            r = $urandom_range(0, a);
            tmp = ld_img[a];
            ld_img[a] = ld_img[r];
            ld_img[r] = tmp;
         end
         load_img();
         gd = $urandom_range(0, 3);
         build_job(gd, 1);
         start_job(gd, 0);
         wait_idle(200);
         chk("rand_finish_cycle", 32'(fin_cyc), 32'(2 + gd + 9 * (last_k + 1)));
         check_s();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
